fractal_sync_rx: RTL and testbench

Receive-side datapath of a fractal synchronization tree node. It collects synchronization requests from the two child ports, east-north (en) and west-south (ws), and buffers each in its own FIFO. It then arbitrates, and optionally merges, them into a single request stream toward the node's control logic, which sees a valid/ready handshake. On the way out it appends two source bits, so that the matching response path can route the reply back by shifting the destination right by 2.

---
 rtl/fractal_sync_rx.sv | 246 ++++++++++++++++++++++++
 tb/tb_fractal_sync_rx.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_rx.sv
// Receive datapath of a fractal sync tree node: per-port FIFOs, round-robin arbitration, source tagging.
// Optional merging of identical en/ws heads is enabled with the FRACTAL_SYNC_RX_MERGE_EN macro.

module fractal_sync_rx_fifo #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              empty_o,
   output logic              overflow_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              full;
   logic              push_ok;
   logic              pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full       = (cnt_q == CNT_W'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   // A push into a full FIFO is dropped even when a pop frees a slot in the same cycle.
   assign push_ok    = push_i && !full;
   assign pop_ok     = pop_i && !empty_o;
   assign overflow_o = push_i && full;
   assign data_o     = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

module fractal_sync_rx #(
   parameter int ID_W       = 8,
   parameter int SRC_W      = 4,
   parameter int COMB_IN    = 0,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_sync_i,
   input  logic [ID_W-1:0]  en_id_i,
   input  logic [SRC_W-1:0] en_src_i,
   input  logic             ws_sync_i,
   input  logic [ID_W-1:0]  ws_id_i,
   input  logic [SRC_W-1:0] ws_src_i,
   output logic             req_valid_o,
   input  logic             req_ready_i,
   output logic [ID_W-1:0]  req_id_o,
   output logic [SRC_W+1:0] req_src_o,
   output logic             en_empty_o,
   output logic             ws_empty_o,
   output logic             en_error_overflow_o,
   output logic             ws_error_overflow_o
);

   localparam int ELEM_W = ID_W + SRC_W;

   typedef enum logic {
      RR_EN = 1'b0,
      RR_WS = 1'b1
   } rr_e;

   if (FIFO_DEPTH <= 0) begin : g_bad_depth
      $fatal(1, "fractal_sync_rx: FIFO_DEPTH must be greater than zero");
   end

   logic              en_push, ws_push;
   logic [ELEM_W-1:0] en_elem, ws_elem;
   logic [ELEM_W-1:0] en_head, ws_head;
   logic              en_pop, ws_pop;
   logic              en_vld, ws_vld;
   logic              grant_en, grant_ws, merge;
   logic              xfer;
   logic              req_valid;
   logic [ID_W-1:0]   req_id;
   logic [SRC_W+1:0]  req_src;
   rr_e               rr_q, rr_d;

   if (COMB_IN != 0) begin : g_comb_in
      assign en_push = en_sync_i;
      assign en_elem = {en_id_i, en_src_i};
      assign ws_push = ws_sync_i;
      assign ws_elem = {ws_id_i, ws_src_i};
   end else begin : g_reg_in
      logic              en_push_q, en_push_d;
      logic              ws_push_q, ws_push_d;
      logic [ELEM_W-1:0] en_elem_q, en_elem_d;
      logic [ELEM_W-1:0] ws_elem_q, ws_elem_d;

      // Sample registers only load on a strobe so an idle port holds its last element.
      always_comb begin
         en_push_d = en_sync_i;
         ws_push_d = ws_sync_i;
         en_elem_d = en_sync_i ? {en_id_i, en_src_i} : en_elem_q;
         ws_elem_d = ws_sync_i ? {ws_id_i, ws_src_i} : ws_elem_q;
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            en_push_q <= 1'b0;
            ws_push_q <= 1'b0;
            en_elem_q <= '0;
            ws_elem_q <= '0;
         end else begin
            en_push_q <= en_push_d;
            ws_push_q <= ws_push_d;
            en_elem_q <= en_elem_d;
            ws_elem_q <= ws_elem_d;
         end
      end

      assign en_push = en_push_q;
      assign en_elem = en_elem_q;
      assign ws_push = ws_push_q;
      assign ws_elem = ws_elem_q;
   end

   fractal_sync_rx_fifo #(
      .DATA_W (ELEM_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_en_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (en_push),
      .data_i     (en_elem),
      .pop_i      (en_pop),
      .data_o     (en_head),
      .empty_o    (en_empty_o),
      .overflow_o (en_error_overflow_o)
   );

   fractal_sync_rx_fifo #(
      .DATA_W (ELEM_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_ws_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (ws_push),
      .data_i     (ws_elem),
      .pop_i      (ws_pop),
      .data_o     (ws_head),
      .empty_o    (ws_empty_o),
      .overflow_o (ws_error_overflow_o)
   );

   assign en_vld    = !en_empty_o;
   assign ws_vld    = !ws_empty_o;
   assign req_valid = en_vld || ws_vld;
   assign xfer      = req_valid && req_ready_i;

   always_comb begin
      merge    = 1'b0;
      grant_en = 1'b0;
      grant_ws = 1'b0;
      req_id   = '0;
      req_src  = '0;
`ifdef FRACTAL_SYNC_RX_MERGE_EN
      merge = en_vld && ws_vld && (en_head == ws_head);
`endif
      if (merge) begin
         req_id  = en_head[ELEM_W-1:SRC_W];
         req_src = {en_head[SRC_W-1:0], 2'b11};
      end else if (en_vld && (!ws_vld || (rr_q == RR_EN))) begin
         grant_en = 1'b1;
         req_id   = en_head[ELEM_W-1:SRC_W];
         req_src  = {en_head[SRC_W-1:0], 2'b01};
      end else if (ws_vld) begin
         grant_ws = 1'b1;
         req_id   = ws_head[ELEM_W-1:SRC_W];
         req_src  = {ws_head[SRC_W-1:0], 2'b10};
      end
   end

   assign en_pop = xfer && (grant_en || merge);
   assign ws_pop = xfer && (grant_ws || merge);

   // Only single-port transfers advance the pointer; a merge serves both ports fairly.
   always_comb begin
      rr_d = rr_q;
      if (xfer && grant_en) begin
         rr_d = RR_WS;
      end else if (xfer && grant_ws) begin
         rr_d = RR_EN;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q <= RR_EN;
      end else begin
         rr_q <= rr_d;
      end
   end

   assign req_valid_o = req_valid;
   assign req_id_o    = req_id;
   assign req_src_o   = req_src;

endmodule

// File: tb/tb_fractal_sync_rx.sv
// Bench for fractal_sync_rx (COMB_IN=0, FIFO_DEPTH=2): directed scenarios plus randomized traffic vs a queue model.

module tb_fractal_sync_rx;

   localparam int ID_W  = 8;
   localparam int SRC_W = 4;
   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_sync = 1'b0, ws_sync = 1'b0;
   logic [7:0] en_id = '0, ws_id = '0;
   logic [3:0] en_src = '0, ws_src = '0;
   logic       ready = 1'b0;
   logic       valid;
   logic [7:0] req_id;
   logic [5:0] req_src;
   logic       en_empty, ws_empty, en_ovf, ws_ovf;

   int errors = 0;
   int checks = 0;

   // Reference model: two bounded queues, a one-cycle input stage per port, and a fairness flag.
   logic [11:0] qen[$];
   logic [11:0] qws[$];
   bit          sen_v, sws_v;
   logic [11:0] sen_e, sws_e;
   bit          rr_ws;

   fractal_sync_rx #(
      .ID_W       (ID_W),
      .SRC_W      (SRC_W),
      .COMB_IN    (0),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .en_sync_i           (en_sync),
      .en_id_i             (en_id),
      .en_src_i            (en_src),
      .ws_sync_i           (ws_sync),
      .ws_id_i             (ws_id),
      .ws_src_i            (ws_src),
      .req_valid_o         (valid),
      .req_ready_i         (ready),
      .req_id_o            (req_id),
      .req_src_o           (req_src),
      .en_empty_o          (en_empty),
      .ws_empty_o          (ws_empty),
      .en_error_overflow_o (en_ovf),
      .ws_error_overflow_o (ws_ovf)
   );

   always #5 clk = ~clk;

   // 0 none, 1 en, 2 ws, 3 merged
   function automatic int m_sel();
      bit both;
      both = (qen.size() != 0) && (qws.size() != 0);
`ifdef FRACTAL_SYNC_RX_MERGE_EN
      if (both && (qen[0] == qws[0])) return 3;
`endif
      if (both) return rr_ws ? 2 : 1;
      if (qen.size() != 0) return 1;
      if (qws.size() != 0) return 2;
      return 0;
   endfunction

   function automatic logic m_valid();
      return (qen.size() != 0) || (qws.size() != 0);
   endfunction

   function automatic logic [7:0] m_id();
      int s;
      s = m_sel();
      if (s == 1 || s == 3) return qen[0][11:4];
      if (s == 2) return qws[0][11:4];
      return 8'h00;
   endfunction

   function automatic logic [5:0] m_src();
      int s;
      s = m_sel();
      if (s == 1) return {qen[0][3:0], 2'b01};
      if (s == 2) return {qws[0][3:0], 2'b10};
      if (s == 3) return {qen[0][3:0], 2'b11};
      return 6'h00;
   endfunction

   // Drive one cycle of inputs, advance the model across the edge, land on the next falling edge.
   task automatic step(input bit r, input bit es, input logic [7:0] eid, input logic [3:0] esrc,
                       input bit wss, input logic [7:0] wid, input logic [3:0] wsrc, input bit rdy);
      int  s;
      bit  en_full, ws_full;
      rst = r; en_sync = es; en_id = eid; en_src = esrc;
      ws_sync = wss; ws_id = wid; ws_src = wsrc; ready = rdy;
      if (r) begin
         qen.delete(); qws.delete();
         sen_v = 0; sws_v = 0; rr_ws = 0;
      end else begin
         s = m_sel();
         en_full = (qen.size() == DEPTH);
         ws_full = (qws.size() == DEPTH);
         if (s != 0 && rdy) begin
            if (s == 1 || s == 3) void'(qen.pop_front());
            if (s == 2 || s == 3) void'(qws.pop_front());
            if (s == 1) rr_ws = 1;
            if (s == 2) rr_ws = 0;
         end
         if (sen_v && !en_full) qen.push_back(sen_e);
         if (sws_v && !ws_full) qws.push_back(sws_e);
         sen_v = es;
         sws_v = wss;
         if (es) sen_e = {eid, esrc};
         if (wss) sws_e = {wid, wsrc};
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, rdy);
   endtask

   task automatic do_reset();
      step(1, 0, 8'h00, 4'h0, 0, 8'h00, 4'h0, 0);
   endtask

   task automatic test_reset();
      do_reset();
      do_reset();
      checks++;
      if ({valid, req_id, req_src} !== 15'h0) begin
         errors++; $display("FAIL reset_outputs: got %h want 0", {valid, req_id, req_src});
      end
      checks++;
      if ({en_empty, ws_empty, en_ovf, ws_ovf} !== 4'b1100) begin
         errors++; $display("FAIL reset_flags: got %b want 1100", {en_empty, ws_empty, en_ovf, ws_ovf});
      end
   endtask

   task automatic test_single();
      do_reset();
      step(0, 1, 8'h05, 4'h3, 0, 8'h00, 4'h0, 1);
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL single_t1: valid got %b want 0", valid);
      end
      idle(1);
      checks++;
      if ({valid, req_id, req_src, en_empty} !== {1'b1, 8'h05, 6'h0D, 1'b0}) begin
         errors++; $display("FAIL single_t2: got v=%b id=%h src=%h e=%b want v=1 id=05 src=0d e=0",
                            valid, req_id, req_src, en_empty);
      end
      idle(1);
      checks++;
      if ({valid, en_empty} !== 2'b01) begin
         errors++; $display("FAIL single_done: got v=%b e=%b want v=0 e=1", valid, en_empty);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      step(0, 1, 8'h11, 4'h1, 1, 8'h22, 4'h2, 1);
      idle(1);
      checks++;
      if ({valid, req_id, req_src} !== {1'b1, 8'h11, 6'h05}) begin
         errors++; $display("FAIL rr_first: got v=%b id=%h src=%h want 1 11 05", valid, req_id, req_src);
      end
      idle(1);
      checks++;
      if ({valid, req_id, req_src} !== {1'b1, 8'h22, 6'h0A}) begin
         errors++; $display("FAIL rr_second: got v=%b id=%h src=%h want 1 22 0a", valid, req_id, req_src);
      end
      idle(1);
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL rr_drain: valid got %b want 0", valid);
      end
      step(0, 1, 8'h33, 4'h4, 1, 8'h44, 4'h5, 0);
      idle(0);
      checks++;
      if ({req_id, req_src} !== {8'h33, 6'h11}) begin
         errors++; $display("FAIL rr_returns_en: got id=%h src=%h want 33 11", req_id, req_src);
      end
   endtask

   task automatic test_merge();
      do_reset();
      step(0, 1, 8'h7A, 4'h2, 1, 8'h7A, 4'h2, 1);
      idle(1);
`ifdef FRACTAL_SYNC_RX_MERGE_EN
      checks++;
      if ({valid, req_id, req_src} !== {1'b1, 8'h7A, 6'h0B}) begin
         errors++; $display("FAIL merge_one: got v=%b id=%h src=%h want 1 7a 0b", valid, req_id, req_src);
      end
      idle(1);
      checks++;
      if ({valid, en_empty, ws_empty} !== 3'b011) begin
         errors++; $display("FAIL merge_pops_both: got %b want 011", {valid, en_empty, ws_empty});
      end
`else
      checks++;
      if ({valid, req_id, req_src} !== {1'b1, 8'h7A, 6'h09}) begin
         errors++; $display("FAIL nomerge_first: got v=%b id=%h src=%h want 1 7a 09", valid, req_id, req_src);
      end
      idle(1);
      checks++;
      if ({valid, req_id, req_src} !== {1'b1, 8'h7A, 6'h0A}) begin
         errors++; $display("FAIL nomerge_second: got v=%b id=%h src=%h want 1 7a 0a", valid, req_id, req_src);
      end
      idle(1);
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL nomerge_drain: valid got %b want 0", valid);
      end
`endif
   endtask

   task automatic test_overflow();
      int pulses;
      pulses = 0;
      do_reset();
      step(0, 1, 8'h01, 4'h0, 0, 8'h00, 4'h0, 0);
      pulses += en_ovf;
      step(0, 1, 8'h02, 4'h0, 0, 8'h00, 4'h0, 0);
      pulses += en_ovf;
      step(0, 1, 8'h03, 4'h0, 0, 8'h00, 4'h0, 0);
      checks++;
      if ({en_ovf, ws_ovf} !== 2'b10) begin
         errors++; $display("FAIL ovf_pulse: got en=%b ws=%b want en=1 ws=0", en_ovf, ws_ovf);
      end
      pulses += en_ovf;
      idle(0);
      pulses += en_ovf;
      idle(0);
      pulses += en_ovf;
      checks++;
      if (pulses != 1) begin
         errors++; $display("FAIL ovf_width: got %0d cycles want 1", pulses);
      end
      checks++;
      if ({valid, req_id} !== {1'b1, 8'h01}) begin
         errors++; $display("FAIL ovf_head1: got v=%b id=%h want 1 01", valid, req_id);
      end
      idle(1);
      checks++;
      if ({valid, req_id} !== {1'b1, 8'h02}) begin
         errors++; $display("FAIL ovf_head2: got v=%b id=%h want 1 02", valid, req_id);
      end
      idle(1);
      checks++;
      if ({valid, en_empty} !== 2'b01) begin
         errors++; $display("FAIL ovf_drain: got v=%b e=%b want 0 1", valid, en_empty);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      bad = 0;
      do_reset();
      step(0, 0, 8'h00, 4'h0, 1, 8'h3C, 4'h5, 0);
      idle(0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({valid, req_id, req_src, ws_empty} !== {1'b1, 8'h3C, 6'h16, 1'b0}) begin
            errors++; bad++;
            $display("FAIL bp_hold[%0d]: got v=%b id=%h src=%h e=%b want 1 3c 16 0",
                     i, valid, req_id, req_src, ws_empty);
         end
         idle(0);
      end
      idle(1);
      checks++;
      if ({valid, ws_empty} !== 2'b01) begin
         errors++; $display("FAIL bp_single_pop: got v=%b e=%b want 0 1", valid, ws_empty);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(0, 1, 8'h01, 4'h1, 1, 8'h02, 4'h2, 0);
      step(0, 1, 8'h03, 4'h3, 1, 8'h04, 4'h4, 0);
      idle(0);
      checks++;
      if ({valid, en_empty, ws_empty} !== 3'b100) begin
         errors++; $display("FAIL rstmid_filled: got %b want 100", {valid, en_empty, ws_empty});
      end
      step(1, 1, 8'h55, 4'h5, 1, 8'h66, 4'h6, 1);
      checks++;
      if ({valid, en_empty, ws_empty} !== 3'b011) begin
         errors++; $display("FAIL rstmid_cleared: got %b want 011", {valid, en_empty, ws_empty});
      end
      idle(0);
      idle(0);
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_sync_dropped: valid got %b want 0", valid);
      end
      step(0, 1, 8'hA0, 4'h1, 1, 8'hB0, 4'h2, 0);
      idle(0);
      checks++;
      if (req_id !== 8'hA0) begin
         errors++; $display("FAIL rstmid_rr_en: got id=%h want a0", req_id);
      end
   endtask

   task automatic test_random();
      bit          r, es, wss, rdy;
      logic [7:0]  eid, wid;
      logic [3:0]  esrc, wsrc;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r    = ($urandom_range(0, 99) == 0);
         es   = ($urandom_range(0, 99) < 55);
         wss  = ($urandom_range(0, 99) < 55);
         rdy  = ($urandom_range(0, 99) < 60);
         eid  = 8'($urandom_range(0, 3));
         wid  = 8'($urandom_range(0, 3));
         esrc = 4'($urandom_range(0, 1));
         wsrc = 4'($urandom_range(0, 1));
         step(r, es, eid, esrc, wss, wid, wsrc, rdy);
         checks++;
         if ({valid, req_id, req_src} !== {m_valid(), m_id(), m_src()}) begin
            errors++;
            $display("FAIL rand_req[%0d]: got v=%b id=%h src=%h want v=%b id=%h src=%h",
                     i, valid, req_id, req_src, m_valid(), m_id(), m_src());
         end
         checks++;
         if ({en_empty, ws_empty} !== {qen.size() == 0, qws.size() == 0}) begin
            errors++;
            $display("FAIL rand_empty[%0d]: got en=%b ws=%b want en=%b ws=%b",
                     i, en_empty, ws_empty, qen.size() == 0, qws.size() == 0);
         end
         checks++;
         if ({en_ovf, ws_ovf} !== {sen_v && (qen.size() == DEPTH), sws_v && (qws.size() == DEPTH)}) begin
            errors++;
            $display("FAIL rand_ovf[%0d]: got en=%b ws=%b want en=%b ws=%b", i, en_ovf, ws_ovf,
                     sen_v && (qen.size() == DEPTH), sws_v && (qws.size() == DEPTH));
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_merge();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
